// File: rtl/mx11_seu_seq.sv
// MX11 SEU instruction sequencer: fetches 28-bit words, drives SEU control fields from IR, strobes rf_we once per retired word.
// Optional breakpoint logic is enabled with the MX11_SEQ_BRK_EN macro (adds brk_en / brk_addr inputs).
module mx11_seu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_addr,
  input  logic        stop,
`ifdef MX11_SEQ_BRK_EN
  input  logic        brk_en,
  input  logic [7:0]  brk_addr,
`endif
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [27:0] imem_rdata,
  output logic        seu_cs_n,
  output logic        seu_fetch,
  output logic        seu_ldi,
  output logic [7:0]  seu_ldv,
  output logic [3:0]  seu_opcode,
  output logic [3:0]  seu_src_a,
  output logic [3:0]  seu_src_b,
  output logic [3:0]  seu_dst_f,
  output logic        rf_we,
  output logic        busy,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d, state_nom;
  logic [7:0]  pc_q, pc_d;
  logic [27:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic        imem_req_q, imem_req_d;
  logic [7:0]  imem_addr_q, imem_addr_d;
  logic        cs_n_q, cs_n_d;
  logic        rf_we_q, rf_we_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic        brk_hit;
  logic        ir_rsvd_unused;

  // Next-state, PC, IR and retired-count computation
  always_comb begin
    state_nom = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nom = ST_FETCH;
          pc_d      = start_addr;
          retired_d = 16'd0;
        end else begin
          state_nom = state_q;
        end
      end
      ST_FETCH: begin
        if (imem_valid) begin
          ir_d      = imem_rdata;
          state_nom = ST_EXEC;
        end else begin
          state_nom = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (ir_q[26]) begin
          state_nom = ST_HALT;
        end else begin
          state_nom = ST_WB;
        end
      end
      ST_WB: begin
        pc_d      = pc_q + 8'd1;
        retired_d = retired_q + 16'd1;
        if (stop) begin
          state_nom = ST_HALT;
        end else begin
          state_nom = ST_FETCH;
        end
      end
      default: begin
        state_nom = ST_IDLE;
      end
    endcase
  end

  // Breakpoint check applies only on entry into FETCH, using the PC about to be fetched
  always_comb begin
    brk_hit = 1'b0;
`ifdef MX11_SEQ_BRK_EN
    if (brk_en && (pc_d == brk_addr) && (state_nom == ST_FETCH) && (state_q != ST_FETCH)) begin
      brk_hit = 1'b1;
    end else begin
      brk_hit = 1'b0;
    end
`endif
    if (brk_hit) begin
      state_d = ST_HALT;
    end else begin
      state_d = state_nom;
    end
  end

  // Output flops are decoded from the next state so every output is a register
  always_comb begin
    imem_req_d  = (state_d == ST_FETCH);
    imem_addr_d = pc_d;
    cs_n_d      = !(((state_d == ST_EXEC) && !ir_d[26]) || (state_d == ST_WB));
    rf_we_d     = (state_d == ST_WB);
    busy_d      = (state_d == ST_FETCH) || (state_d == ST_EXEC) || (state_d == ST_WB);
    halted_d    = (state_d == ST_HALT);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= 8'd0;
      ir_q        <= 28'd0;
      retired_q   <= 16'd0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 8'd0;
      cs_n_q      <= 1'b1;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      cs_n_q      <= cs_n_d;
      rf_we_q     <= rf_we_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  // Bit 24 of the instruction word is reserved and has no consumer
  assign ir_rsvd_unused = ir_q[24];

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign seu_cs_n   = cs_n_q;
  assign seu_ldi    = ir_q[27];
  assign seu_fetch  = ir_q[25];
  assign seu_opcode = ir_q[23:20];
  assign seu_dst_f  = ir_q[19:16];
  assign seu_src_a  = ir_q[15:12];
  assign seu_src_b  = ir_q[11:8];
  assign seu_ldv    = ir_q[7:0];
  assign rf_we      = rf_we_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mx11_seu_seq.sv
// Scoreboard bench for mx11_seu_seq: stimulus pushes expected fetch addresses and SEU fields, a forked monitor checks them.
// Define MX11_SEQ_BRK_EN to also exercise the breakpoint.
module tb_mx11_seu_seq;
  logic        clk = 1'b0;
  logic        rst, start, stop, imem_valid;
  logic [7:0]  start_addr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [27:0] imem_rdata;
  logic        seu_cs_n, seu_fetch, seu_ldi, rf_we, busy, halted;
  logic [7:0]  seu_ldv;
  logic [3:0]  seu_opcode, seu_src_a, seu_src_b, seu_dst_f;
  logic [15:0] retired;
`ifdef MX11_SEQ_BRK_EN
  logic        brk_en;
  logic [7:0]  brk_addr;
`endif

  logic [27:0] mem [0:255];
  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mx11_seu_seq dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .stop(stop),
`ifdef MX11_SEQ_BRK_EN
    .brk_en(brk_en), .brk_addr(brk_addr),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .seu_cs_n(seu_cs_n), .seu_fetch(seu_fetch), .seu_ldi(seu_ldi), .seu_ldv(seu_ldv),
    .seu_opcode(seu_opcode), .seu_src_a(seu_src_a), .seu_src_b(seu_src_b), .seu_dst_f(seu_dst_f),
    .rf_we(rf_we), .busy(busy), .halted(halted), .retired(retired)
  );

  typedef struct packed {
    logic       ldi;
    logic       fetch;
    logic [3:0] op;
    logic [3:0] dst;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [7:0] ldv;
  } wb_t;

  wb_t        wb_q[$];
  logic [7:0] fetch_q[$];
  int errors = 0;
  int checks = 0;
  int cs_low_total = 0;
  int we_total = 0;
  int last_we_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    wb_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req && imem_valid) begin
          if (fetch_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fetch: got addr %0h expected no fetch", imem_addr);
          end else begin
            chk("fetch_addr", {24'd0, imem_addr}, {24'd0, fetch_q.pop_front()});
          end
        end
        if (!seu_cs_n) cs_low_total++;
        if (rf_we) begin
          we_total++;
          last_we_cyc = cyc;
          chk("rf_we_cs_n", {31'd0, seu_cs_n}, 32'd0);
        end
        if (!seu_cs_n) begin
          if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_exec: got cs_n low expected none");
          end else begin
            e = rf_we ? wb_q.pop_front() : wb_q[0];
            chk("seu_fields", {6'd0, seu_ldi, seu_fetch, seu_opcode, seu_dst_f, seu_src_a, seu_src_b, seu_ldv},
                {6'd0, e});
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] addr);
    start_addr = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 40 && !halted; i++) tick();
    chk(name, {31'd0, halted}, 32'd1);
  endtask

  int s, cs0, we0;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; imem_valid = 1'b0; start_addr = 8'h00;
`ifdef MX11_SEQ_BRK_EN
    brk_en = 1'b0; brk_addr = 8'h00;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 28'h0123456;
    fork
      monitor();
    join_none
    repeat (3) tick();

    // reset values
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_cs_n", {31'd0, seu_cs_n}, 32'd1);
    chk("rst_fields", {6'd0, seu_ldi, seu_fetch, seu_opcode, seu_dst_f, seu_src_a, seu_src_b, seu_ldv}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_busy_halted", {30'd0, busy, halted}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);

    // reset while stuck in FETCH
    rst = 1'b0;
    pulse_start(8'h40);
    tick();
    chk("t1_req_before_rst", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'h40});
    rst = 1'b1;
    tick();
    chk("t1_req_after_rst", {31'd0, imem_req}, 32'd0);
    chk("t1_cs_n_after_rst", {31'd0, seu_cs_n}, 32'd1);
    chk("t1_busy_retired", {15'd0, busy, retired}, 32'd0);
    rst = 1'b0;
    imem_valid = 1'b1;
    repeat (3) tick();
    chk("t1_stay_idle", {30'd0, busy, imem_req}, 32'd0);

    // ADD then halt at 0x10
    mem[8'h10] = 28'h0112300;
    mem[8'h11] = 28'h4000000;
    fetch_q.push_back(8'h10); fetch_q.push_back(8'h11);
    wb_q.push_back('{ldi:1'b0, fetch:1'b0, op:4'h1, dst:4'h1, sa:4'h2, sb:4'h3, ldv:8'h00});
    cs0 = cs_low_total; we0 = we_total;
    pulse_start(8'h10);
    wait_halt("t2_halted");
    chk("t2_cs_low_cycles", cs_low_total - cs0, 32'd2);
    chk("t2_rf_we_count", we_total - we0, 32'd1);
    chk("t2_retired", {16'd0, retired}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    // LDI with page bit, restart from HALT clears retired
    mem[8'h20] = 28'hA0400A5;
    mem[8'h21] = 28'h4987654;
    fetch_q.push_back(8'h20); fetch_q.push_back(8'h21);
    wb_q.push_back('{ldi:1'b1, fetch:1'b1, op:4'h0, dst:4'h4, sa:4'h0, sb:4'h0, ldv:8'hA5});
    pulse_start(8'h20);
    wait_halt("t3_halted");
    chk("t3_retired", {16'd0, retired}, 32'd1);

    // imem_valid low for three FETCH cycles
    imem_valid = 1'b0;
    mem[8'h30] = 28'h025673C;
    mem[8'h31] = 28'h4000000;
    fetch_q.push_back(8'h30); fetch_q.push_back(8'h31);
    wb_q.push_back('{ldi:1'b0, fetch:1'b0, op:4'h2, dst:4'h5, sa:4'h6, sb:4'h7, ldv:8'h3C});
    pulse_start(8'h30);
    s = cyc;
    repeat (3) begin
      @(negedge clk);
      chk("t4_ir_hold", {20'd0, seu_opcode, seu_ldv}, {20'd0, 4'h9, 8'h54});
      chk("t4_req_held", {31'd0, imem_req}, 32'd1);
      tick();
    end
    imem_valid = 1'b1;
    wait_halt("t4_halted");
    chk("t4_wb_latency", last_we_cyc - s, 32'd5);
    chk("t4_retired", {16'd0, retired}, 32'd1);

    // PC wrap FF->00 with stop during the second instruction
    mem[8'hFF] = 28'h0389A11;
    mem[8'h00] = 28'h04BCD22;
    mem[8'h01] = 28'h0123456;
    fetch_q.push_back(8'hFF); fetch_q.push_back(8'h00);
    wb_q.push_back('{ldi:1'b0, fetch:1'b0, op:4'h3, dst:4'h8, sa:4'h9, sb:4'hA, ldv:8'h11});
    wb_q.push_back('{ldi:1'b0, fetch:1'b0, op:4'h4, dst:4'hB, sa:4'hC, sb:4'hD, ldv:8'h22});
    pulse_start(8'hFF);
    for (int i = 0; i < 20 && !rf_we; i++) tick();
    chk("t5_first_wb", {31'd0, rf_we}, 32'd1);
    tick();
    stop = 1'b1;
    wait_halt("t5_halted");
    stop = 1'b0;
    chk("t5_retired", {16'd0, retired}, 32'd2);
    chk("t5_no_req", {31'd0, imem_req}, 32'd0);

`ifdef MX11_SEQ_BRK_EN
    // breakpoint at 0x12 stops before fetching it
    brk_en = 1'b1; brk_addr = 8'h12;
    mem[8'h10] = 28'h0112300;
    mem[8'h11] = 28'h0389A11;
    mem[8'h12] = 28'h0123456;
    fetch_q.push_back(8'h10); fetch_q.push_back(8'h11);
    wb_q.push_back('{ldi:1'b0, fetch:1'b0, op:4'h1, dst:4'h1, sa:4'h2, sb:4'h3, ldv:8'h00});
    wb_q.push_back('{ldi:1'b0, fetch:1'b0, op:4'h3, dst:4'h8, sa:4'h9, sb:4'hA, ldv:8'h11});
    pulse_start(8'h10);
    wait_halt("t6_halted");
    chk("t6_retired", {16'd0, retired}, 32'd2);
    repeat (3) tick();
    brk_en = 1'b0;
`endif

    repeat (3) tick();
    chk("fetch_queue_drained", fetch_q.size(), 32'd0);
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
